// File: rtl/p405s_dcu_plb_rd_fill_if.sv
// Bundle of DCU fill-request, PLB read-data and line-fill result signals.
// The fill unit sits on the slave modport. The DCU/PLB side (or a bench) sits on master.
interface p405s_dcu_plb_rd_fill_if #(
  parameter int LINE_DW = 4,
  parameter int DW      = 64
);
  localparam int AW = $clog2(LINE_DW);

  logic                     DCU_fillReq;
  logic [AW-1:0]            DCU_fillTgtDw;
  logic                     DCU_fillAbort;
  logic                     PLB_dcuRdDAck;
  logic [AW-1:0]            PLB_dcuRdWdAddr;
  logic [0:DW-1]            PLB_dcuRdDBus;
  logic                     PLB_dcuRdComp;
  logic                     fillBusy;
  logic                     critValid;
  logic [0:DW-1]            critData;
  logic                     fillDone;
  logic [0:LINE_DW*DW-1]    fillLine;
  logic                     fillErr;

  modport master (
    output DCU_fillReq, DCU_fillTgtDw, DCU_fillAbort,
    output PLB_dcuRdDAck, PLB_dcuRdWdAddr, PLB_dcuRdDBus, PLB_dcuRdComp,
    input  fillBusy, critValid, critData, fillDone, fillLine, fillErr
  );

  modport slave (
    input  DCU_fillReq, DCU_fillTgtDw, DCU_fillAbort,
    input  PLB_dcuRdDAck, PLB_dcuRdWdAddr, PLB_dcuRdDBus, PLB_dcuRdComp,
    output fillBusy, critValid, critData, fillDone, fillLine, fillErr
  );
endinterface

// File: rtl/p405s_dcu_plb_rd_fill.sv
// DCU line-fill capture from the PLB read-data bus.
// Beats may arrive in any order. Each beat is placed by its doubleword address, and the target
// doubleword is forwarded early. The finished line is presented with a one-cycle fillDone pulse.
// A duplicate beat or an early complete ends the fill with a one-cycle fillErr pulse.
module p405s_dcu_plb_rd_fill #(
  parameter int LINE_DW = 4,
  parameter int DW      = 64
) (
  input logic CB,
  input logic rstN,
  p405s_dcu_plb_rd_fill_if.slave bus
);
  localparam int AW = $clog2(LINE_DW);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, FILL, DONE, ERR} state_t;

  state_t                 stateQ, stateD;
  logic [LINE_DW-1:0]     maskQ;
  logic [CW-1:0]          cntQ;
  logic [AW-1:0]          tgtQ;
  logic [0:DW-1]          critDataQ;
  logic [0:LINE_DW*DW-1]  lineQ;
  logic                   critValidQ;
  logic                   fillDoneQ;
  logic                   fillErrQ;

  logic                   beatHit;
  logic                   beatDup;
  logic                   beatNew;
  logic                   lastBeat;

  // State register; reset drops straight back to IDLE
  always_ff @(posedge CB or negedge rstN) begin
    if (!rstN) stateQ <= IDLE;
    else       stateQ <= stateD;
  end

  // Beat classification and next state: abort beats everything, then duplicate, then completion
  always_comb begin
    beatHit  = (stateQ == FILL) && bus.PLB_dcuRdDAck && !bus.DCU_fillAbort;
    beatDup  = beatHit && maskQ[bus.PLB_dcuRdWdAddr];
    beatNew  = beatHit && !maskQ[bus.PLB_dcuRdWdAddr];
    lastBeat = beatNew && (cntQ == CW'(LINE_DW - 1));
    stateD   = stateQ;
    case (stateQ)
      IDLE: if (bus.DCU_fillReq) stateD = FILL;
      FILL: begin
        if (bus.DCU_fillAbort)       stateD = IDLE;
        else if (beatDup)            stateD = ERR;
        else if (lastBeat)           stateD = DONE;
        else if (bus.PLB_dcuRdComp)  stateD = ERR;
      end
      DONE:    stateD = IDLE;
      ERR:     stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Fill datapath: latch target on request, place accepted beats, forward the critical doubleword
  always_ff @(posedge CB or negedge rstN) begin
    if (!rstN) begin
      maskQ      <= '0;
      cntQ       <= '0;
      tgtQ       <= '0;
      critDataQ  <= '0;
      lineQ      <= '0;
      critValidQ <= 1'b0;
      fillDoneQ  <= 1'b0;
      fillErrQ   <= 1'b0;
    end else begin
      critValidQ <= beatNew && (bus.PLB_dcuRdWdAddr == tgtQ);
      fillDoneQ  <= (stateD == DONE);
      fillErrQ   <= (stateD == ERR);
      if (stateQ == IDLE && bus.DCU_fillReq) begin
        tgtQ  <= bus.DCU_fillTgtDw;
        maskQ <= '0;
        cntQ  <= '0;
      end
      if (beatNew) begin
        lineQ[int'(bus.PLB_dcuRdWdAddr) * DW +: DW] <= bus.PLB_dcuRdDBus;
        maskQ[bus.PLB_dcuRdWdAddr]                  <= 1'b1;
        cntQ                                        <= cntQ + 1'b1;
        if (bus.PLB_dcuRdWdAddr == tgtQ) critDataQ <= bus.PLB_dcuRdDBus;
      end
    end
  end

  assign bus.fillBusy  = (stateQ != IDLE);
  assign bus.critValid = critValidQ;
  assign bus.critData  = critDataQ;
  assign bus.fillDone  = fillDoneQ;
  assign bus.fillLine  = lineQ;
  assign bus.fillErr   = fillErrQ;
endmodule
